pe_wb_scheduler: RTL

- Wishbone-slave request scheduler that sequences the external 8-input priority encoder datapath (io_en / io_in[7:0] → io_out[2:0], wb_eno, wb_gs).
- Collects request bits from hardware lines and Wishbone writes into a pending register, and masks them.
- Feeds the masked pending vector to the encoder, captures the encoder result, and issues one grant at a time over a valid/ack handshake.
- Sits between the Wishbone port of the user wrapper and the encoder instance.

---
 rtl/pe_wb_scheduler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/pe_wb_scheduler.sv
// pe_wb_scheduler: Wishbone-slave request scheduler for an external 8-input
// priority encoder. Requests from hardware lines and bus writes collect in
// PEND. The masked vector is handed to the encoder, and the encoder result is
// offered as a single grant over a valid/ack handshake.
`timescale 1ns/1ps
module pe_wb_scheduler #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic [7:0]  req_i,
    output logic        pe_en_o,
    output logic [7:0]  pe_in_o,
    input  logic [2:0]  pe_out_i,
    input  logic        pe_gs_i,
    input  logic        pe_eno_i,
    output logic        grant_valid_o,
    output logic [2:0]  grant_idx_o,
    input  logic        grant_ack_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EVAL    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_GRANT   = 2'd3
    } state_t;

    localparam logic [2:0] OFF_PEND  = 3'd0;
    localparam logic [2:0] OFF_CLR   = 3'd1;
    localparam logic [2:0] OFF_MASK  = 3'd2;
    localparam logic [2:0] OFF_GRANT = 3'd3;
    localparam logic [2:0] OFF_CTRL  = 3'd4;
    localparam logic [2:0] OFF_COUNT = 3'd5;

    // Index of the highest set bit; used to cross-check the encoder result.
    function automatic logic [2:0] msb_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t           state_r, state_n_s;
    logic [7:0]       pend_r, mask_r, req_q_r, pe_in_r;
    logic             en_r, err_r;
    logic [CNT_W-1:0] count_r;
    logic [2:0]       grant_idx_r;
    logic             pe_en_r, grant_valid_r, ack_r;
    logic [31:0]      dat_r;

    logic        hit_s, access_s, wr_s;
    logic [2:0]  off_s;
    logic        wr_pend_s, wr_clr_s, wr_mask_s, wr_ctrl_s;
    logic [7:0]  vec_s, edge_s, set_s, clr_s, pend_n_s;
    logic        take_s, cap_s, cap_err_s;
    logic [31:0] rdata_s;
    logic        pe_en_n_s, grant_valid_n_s;
    logic        unused_s;

    assign hit_s     = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign access_s  = wbs_cyc_i & wbs_stb_i & hit_s & ~ack_r;
    assign wr_s      = access_s & wbs_we_i & wbs_sel_i[0];
    assign off_s     = wbs_adr_i[4:2];
    assign wr_pend_s = wr_s & (off_s == OFF_PEND);
    assign wr_clr_s  = wr_s & (off_s == OFF_CLR);
    assign wr_mask_s = wr_s & (off_s == OFF_MASK);
    assign wr_ctrl_s = wr_s & (off_s == OFF_CTRL);

    assign vec_s  = pend_r & mask_r;
    assign edge_s = req_i & ~req_q_r;
    assign take_s = (state_r == ST_GRANT) & en_r & grant_ack_i;
    assign cap_s  = (state_r == ST_CAPTURE) & en_r & pe_gs_i;
    assign cap_err_s = cap_s & ((pe_out_i != msb_index(pe_in_r)) | pe_eno_i);

    // Sets (edge or W1S) are applied after both kinds of clear, so a set wins.
    assign set_s    = edge_s | (wr_pend_s ? wbs_dat_i[7:0] : 8'h00);
    assign clr_s    = (wr_clr_s ? wbs_dat_i[7:0] : 8'h00)
                    | (take_s ? (8'h01 << grant_idx_r) : 8'h00);
    assign pend_n_s = (pend_r & ~clr_s) | set_s;

    assign unused_s = ^{wbs_sel_i[3:1], wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_dat_i[31:8]};

    // Read-data multiplexer over the register map.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (off_s)
            OFF_PEND:  rdata_s = {24'h00_0000, pend_r};
            OFF_CLR:   rdata_s = 32'h0000_0000;
            OFF_MASK:  rdata_s = {24'h00_0000, mask_r};
            OFF_GRANT: rdata_s = {16'h0000, err_r, 6'h00, grant_valid_r, 5'h00, grant_idx_r};
            OFF_CTRL:  rdata_s = {31'h0000_0000, en_r};
            OFF_COUNT: rdata_s = 32'(count_r);
            default:   rdata_s = 32'h0000_0000;
        endcase
    end

    // Wishbone acknowledge and read data, one registered ack per access.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= access_s;
            dat_r <= access_s ? rdata_s : 32'h0000_0000;
        end
    end

    // Control and status registers: pending, mask, enable, sticky error, count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pend_r  <= 8'h00;
            mask_r  <= 8'hFF;
            en_r    <= 1'b0;
            err_r   <= 1'b0;
            count_r <= '0;
            req_q_r <= 8'h00;
        end else begin
            req_q_r <= req_i;
            pend_r  <= pend_n_s;
            mask_r  <= wr_mask_s ? wbs_dat_i[7:0] : mask_r;
            en_r    <= wr_ctrl_s ? wbs_dat_i[0] : en_r;
            if (cap_err_s) begin
                err_r <= 1'b1;
            end else if (wr_ctrl_s && wbs_dat_i[1]) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            count_r <= take_s ? (count_r + CNT_W'(1)) : count_r;
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic; a cleared EN pulls every state back to IDLE.
    always_comb begin
        state_n_s = state_r;
        if (!en_r) begin
            state_n_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_n_s = (|vec_s) ? ST_EVAL : ST_IDLE;
                ST_EVAL:    state_n_s = ST_CAPTURE;
                ST_CAPTURE: state_n_s = pe_gs_i ? ST_GRANT : ST_IDLE;
                ST_GRANT: begin
                    if (grant_ack_i) begin
                        state_n_s = ST_IDLE;
                    end else if (!vec_s[grant_idx_r]) begin
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = ST_GRANT;
                    end
                end
                default:    state_n_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs, decoded from the next state so they can be registered.
    always_comb begin
        pe_en_n_s       = 1'b0;
        grant_valid_n_s = 1'b0;
        case (state_n_s)
            ST_EVAL:    pe_en_n_s       = 1'b1;
            ST_CAPTURE: pe_en_n_s       = 1'b1;
            ST_GRANT:   grant_valid_n_s = 1'b1;
            default: begin
                pe_en_n_s       = 1'b0;
                grant_valid_n_s = 1'b0;
            end
        endcase
    end

    // Output registers: encoder drive, vector snapshot and captured grant index.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pe_en_r       <= 1'b0;
            grant_valid_r <= 1'b0;
            pe_in_r       <= 8'h00;
            grant_idx_r   <= 3'd0;
        end else begin
            pe_en_r       <= pe_en_n_s;
            grant_valid_r <= grant_valid_n_s;
            if ((state_r == ST_IDLE) && (state_n_s == ST_EVAL)) begin
                pe_in_r <= vec_s;
            end else begin
                pe_in_r <= pe_in_r;
            end
            grant_idx_r   <= cap_s ? pe_out_i : grant_idx_r;
        end
    end

    assign wbs_ack_o     = ack_r;
    assign wbs_dat_o     = dat_r;
    assign pe_en_o       = pe_en_r;
    assign pe_in_o       = pe_in_r;
    assign grant_valid_o = grant_valid_r;
    assign grant_idx_o   = grant_idx_r;
    assign irq_o         = grant_valid_r;

endmodule
